// File: rtl/game_pkg.sv
// Shared keyboard/game definitions: keycodes, event-queue FSM states,
// the queued event record and the keycode-to-action decoder.
package game_pkg;

    localparam logic [7:0] KC_NONE  = 8'h00;
    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_UP    = 8'h52;
    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_RIGHT = 8'h4F;

    typedef enum logic [1:0] {
        KQ_IDLE       = 2'd0,
        KQ_PUSH_REL   = 2'd1,
        KQ_PUSH_PRESS = 2'd2
    } kq_state_t;

    typedef struct packed {
        logic       press;
        logic [7:0] code;
    } key_event_t;

    // Bit order: {ig_right, ig_left, ig_jump, fb_right, fb_left, fb_jump}
    function automatic logic [5:0] decode_action(input logic [7:0] kc);
        logic [5:0] act;
        act = 6'b000000;
        case (kc)
            KC_W:     act = 6'b000001;
            KC_A:     act = 6'b000010;
            KC_D:     act = 6'b000100;
            KC_UP:    act = 6'b001000;
            KC_LEFT:  act = 6'b010000;
            KC_RIGHT: act = 6'b100000;
            default:  act = 6'b000000;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// Signal bundle between the key event queue and its producer/consumer.
// Handshake: an event transfers on a cycle where ev_valid && ev_ready; the
// head (ev_press/ev_code) is meaningful only while ev_valid and holds until popped.
interface key_event_queue_if;

    logic [7:0] keycode;
    logic       frame_clk;
    logic       ev_ready;
    logic       ovf_clr;
    logic       ev_valid;
    logic       ev_press;
    logic [7:0] ev_code;
    logic [5:0] action_held;
    logic       frame_tick;
    logic       overflow;

    modport master (
        output keycode, frame_clk, ev_ready, ovf_clr,
        input  ev_valid, ev_press, ev_code, action_held, frame_tick, overflow
    );

    modport slave (
        input  keycode, frame_clk, ev_ready, ovf_clr,
        output ev_valid, ev_press, ev_code, action_held, frame_tick, overflow
    );

endinterface

// File: rtl/key_fifo.sv
// Event FIFO: count-based empty/full, head readable combinationally,
// drops (and flags) a write that finds it full with no pop in the same cycle.
module key_fifo
    import game_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       wr_en_i,
    input  key_event_t wr_data_i,
    input  logic       rd_ready_i,
    output logic       rd_valid_o,
    output key_event_t rd_data_o,
    output logic       drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    key_event_t    mem_q [DEPTH];

    logic empty, full, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign pop   = !empty && rd_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push  = wr_en_i && (!full || pop);
    assign drop_o = wr_en_i && full && !pop;

    assign rd_valid_o = !empty;
    assign rd_data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/key_event_queue.sv
// Debounces the keycode, turns each accepted change into release/press
// events queued in a FIFO, and latches decoded actions once per frame.
module key_event_queue
    import game_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int STABLE_CYC = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    key_event_queue_if.slave  bus,
    output kq_state_t         dbg_state_o
);

    logic [7:0] samp_q [STABLE_CYC];
    logic [7:0] acc_kc_q, acc_kc_d;
    logic [7:0] old_kc_q, old_kc_d;
    kq_state_t  state_q, state_d;
    logic       sync1_q, sync2_q, sync3_q;
    logic [5:0] action_q;
    logic       ovf_q;

    logic       stable, accept, wr_en, drop, fifo_valid;
    key_event_t wr_data, head;

    always_comb begin
        stable = 1'b1;
        for (int i = 1; i < STABLE_CYC; i++) begin
            if (samp_q[i] != samp_q[0]) stable = 1'b0;
        end
    end

    assign accept = (state_q == KQ_IDLE) && stable && (samp_q[0] != acc_kc_q);

    always_comb begin
        state_d  = state_q;
        acc_kc_d = acc_kc_q;
        old_kc_d = old_kc_q;
        wr_en    = 1'b0;
        wr_data  = '0;
        case (state_q)
            KQ_IDLE: begin
                if (accept) begin
                    acc_kc_d = samp_q[0];
                    old_kc_d = acc_kc_q;
                    if (acc_kc_q != KC_NONE)
                        state_d = KQ_PUSH_REL;
                    else if (samp_q[0] != KC_NONE)
                        state_d = KQ_PUSH_PRESS;
                end
            end
            KQ_PUSH_REL: begin
                wr_en   = 1'b1;
                wr_data = '{press: 1'b0, code: old_kc_q};
                state_d = (acc_kc_q != KC_NONE) ? KQ_PUSH_PRESS : KQ_IDLE;
            end
            KQ_PUSH_PRESS: begin
                wr_en   = 1'b1;
                wr_data = '{press: 1'b1, code: acc_kc_q};
                state_d = KQ_IDLE;
            end
            default: state_d = KQ_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < STABLE_CYC; i++) samp_q[i] <= '0;
            acc_kc_q <= '0;
            old_kc_q <= '0;
            state_q  <= KQ_IDLE;
        end else begin
            samp_q[0] <= bus.keycode;
            for (int i = 1; i < STABLE_CYC; i++) samp_q[i] <= samp_q[i-1];
            acc_kc_q <= acc_kc_d;
            old_kc_q <= old_kc_d;
            state_q  <= state_d;
        end
    end

    // frame_clk crosses from the VGA domain: two sync flops plus one for edge detect.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            action_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            sync1_q <= bus.frame_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (bus.frame_tick) action_q <= decode_action(acc_kc_q);
            if (drop)             ovf_q <= 1'b1;
            else if (bus.ovf_clr) ovf_q <= 1'b0;
        end
    end

    key_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .rd_ready_i (bus.ev_ready),
        .rd_valid_o (fifo_valid),
        .rd_data_o  (head),
        .drop_o     (drop)
    );

    assign bus.ev_valid    = fifo_valid;
    assign bus.ev_press    = fifo_valid & head.press;
    assign bus.ev_code     = head.code & {8{fifo_valid}};
    assign bus.frame_tick  = sync2_q & ~sync3_q;
    assign bus.action_held = action_q;
    assign bus.overflow    = ovf_q;
    assign dbg_state_o     = state_q;

endmodule
